// File: rtl/slew_limit_signed.sv
// slew_limit_signed
//   Rate limiter for a valid-strobed signed sample stream. Each accepted sample
//   moves the held output toward the clamped target by at most +/-rate counts.
//   Stage 1 (IDLE): clamps the target and registers delta = tgt - q at W+1 bits.
//   Stage 2 (LIMIT): limits delta to +/-rate, updates q and pulses qv.
//
// Ports
//   c         clock
//   rst       synchronous active-high reset
//   clamp     unsigned magnitude limit (saturated to 2^(W-1)-1)
//   rate      unsigned max |step| per accepted sample (0 freezes q)
//   d, dv     signed target sample and its 1-cycle valid strobe
//   load      preset strobe, overrides dv and any in-flight sample
//   load_val  signed preset value (clamped before use)
//   clr_drop  clears the sticky drop flag
//   q, qv     rate-limited output and its 1-cycle update strobe
//   slewing   last update was rate-limited
//   drop      sticky: a dv arrived while a sample was in flight

module slew_limit_signed #(
  parameter int W = 16
) (
  input  logic                c,
  input  logic                rst,
  input  logic [W-1:0]        clamp,
  input  logic [W-1:0]        rate,
  input  logic signed [W-1:0] d,
  input  logic                dv,
  input  logic                load,
  input  logic signed [W-1:0] load_val,
  input  logic                clr_drop,
  output logic signed [W-1:0] q,
  output logic                qv,
  output logic                slewing,
  output logic                drop
);

  typedef enum logic {
    IDLE  = 1'b0,
    LIMIT = 1'b1
  } state_t;

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  state_t              state;
  logic signed [W:0]   delta_r;

  logic [W-1:0]        clamp_e;
  logic signed [W:0]   clamp_pos;
  logic signed [W-1:0] tgt;
  logic signed [W-1:0] load_sat;
  logic signed [W:0]   delta_next;
  logic signed [W+1:0] delta_x;
  logic signed [W+1:0] rate_x;
  logic signed [W+1:0] step_x;
  logic signed [W-1:0] q_sum;

  // Symmetric saturation of a W-bit value to [-lim, +lim]; lim is always
  // non-negative and <= 2^(W-1)-1, so both bounds fit in W bits.
  function automatic logic signed [W-1:0] sat_sym(input logic signed [W-1:0] v,
                                                  input logic signed [W:0]   lim);
    logic signed [W:0] v_x;
    logic signed [W:0] lim_n;
    v_x   = {v[W-1], v};
    lim_n = -lim;
    if (v_x > lim)
      sat_sym = lim[W-1:0];
    else if (v_x < lim_n)
      sat_sym = lim_n[W-1:0];
    else
      sat_sym = v;
  endfunction

  always_comb begin
    clamp_e    = (clamp > MAX_POS) ? MAX_POS : clamp;
    clamp_pos  = $signed({1'b0, clamp_e});
    tgt        = sat_sym(d, clamp_pos);
    load_sat   = sat_sym(load_val, clamp_pos);
    delta_next = $signed({tgt[W-1], tgt}) - $signed({q[W-1], q});

    // W+2 bits so +/-rate (up to 2^W-1) and delta compare without wrap.
    delta_x = {delta_r[W], delta_r};
    rate_x  = $signed({2'b00, rate});
    if (delta_x > rate_x)
      step_x = rate_x;
    else if (delta_x < -rate_x)
      step_x = -rate_x;
    else
      step_x = delta_x;

    // step never overshoots tgt, so the W-bit sum cannot wrap.
    q_sum = q + step_x[W-1:0];
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state   <= IDLE;
      delta_r <= '0;
      q       <= '0;
      qv      <= 1'b0;
      slewing <= 1'b0;
      drop    <= 1'b0;
    end else begin
      qv <= 1'b0;
      if (clr_drop)
        drop <= 1'b0;
      if (load) begin
        q       <= load_sat;
        qv      <= 1'b1;
        slewing <= 1'b0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (dv) begin
              delta_r <= delta_next;
              state   <= LIMIT;
            end
          end
          LIMIT: begin
            q       <= q_sum;
            slewing <= (step_x != delta_x);
            qv      <= 1'b1;
            state   <= IDLE;
            // A drop event overrides a same-cycle clr_drop.
            if (dv)
              drop <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slew_limit_signed.sv
// tb_slew_limit_signed
//   Directed bench for slew_limit_signed (W=16). Inputs change 1 time unit
//   after the rising edge; outputs are checked at the same point.

module tb_slew_limit_signed;

  logic        c;
  logic        rst;
  logic [15:0] clamp;
  logic [15:0] rate;
  logic [15:0] d;
  logic        dv;
  logic        load;
  logic [15:0] load_val;
  logic        clr_drop;
  logic [15:0] q;
  logic        qv;
  logic        slewing;
  logic        drop;

  int n_checks = 0;
  int n_fail   = 0;

  slew_limit_signed #(.W(16)) dut (
    .c        (c),
    .rst      (rst),
    .clamp    (clamp),
    .rate     (rate),
    .d        (d),
    .dv       (dv),
    .load     (load),
    .load_val (load_val),
    .clr_drop (clr_drop),
    .q        (q),
    .qv       (qv),
    .slewing  (slewing),
    .drop     (drop)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] eq, input logic eqv,
                         input logic eslew, input logic edrop);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".qv"}, {15'd0, qv}, {15'd0, eqv});
    chk({tag, ".slewing"}, {15'd0, slewing}, {15'd0, eslew});
    chk({tag, ".drop"}, {15'd0, drop}, {15'd0, edrop});
  endtask

  initial begin
    rst = 1'b1; clamp = 16'd1000; rate = 16'd100; d = '0; dv = 1'b0;
    load = 1'b0; load_val = '0; clr_drop = 1'b0;
    step(); step();
    chk_out("reset", 16'd0, 1'b0, 1'b0, 1'b0);

    // Reset held 3 cycles while a sample is in flight.
    rst = 1'b0; d = 16'd500; dv = 1'b1;
    step();
    dv = 1'b0; rst = 1'b1;
    step(); step(); step();
    chk_out("rst_mid", 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Stepping toward 500 at rate 100, one dv every second cycle.
    for (int i = 1; i <= 5; i++) begin
      d = 16'd500; dv = 1'b1;
      step();
      chk("ramp.qv_pre", {15'd0, qv}, 16'd0);
      dv = 1'b0;
      step();
      chk_out($sformatf("ramp%0d", i), 16'(i * 100), 1'b1, (i < 5), 1'b0);
    end
    step();
    chk_out("ramp_hold", 16'd500, 1'b0, 1'b0, 1'b0);

    // Unlimited rate, clamp 300: single update to -300.
    clamp = 16'd300; rate = 16'hFFFF;
    load = 1'b1; load_val = 16'd0;
    step();
    chk_out("load0", 16'd0, 1'b1, 1'b0, 1'b0);
    load = 1'b0; d = -16'sd2000; dv = 1'b1;
    step();
    dv = 1'b0;
    step();
    chk_out("clampneg", -16'sd300, 1'b1, 1'b0, 1'b0);

    // Back-to-back dv: second is dropped.
    clamp = 16'd1000; rate = 16'd100; d = 16'd0; dv = 1'b1;
    step();
    step();
    chk_out("b2b", -16'sd200, 1'b1, 1'b1, 1'b1);
    dv = 1'b0;
    step();
    chk_out("b2b_after", -16'sd200, 1'b0, 1'b1, 1'b1);
    step();
    chk("drop_sticky", {15'd0, drop}, 16'd1);
    clr_drop = 1'b1;
    step();
    clr_drop = 1'b0;
    chk("drop_clr", {15'd0, drop}, 16'd0);

    // Drop event beats a same-cycle clr_drop.
    d = -16'sd200; dv = 1'b1;
    step();
    clr_drop = 1'b1;
    step();
    clr_drop = 1'b0; dv = 1'b0;
    chk_out("drop_wins", -16'sd200, 1'b1, 1'b0, 1'b1);
    clr_drop = 1'b1;
    step();
    clr_drop = 1'b0;
    chk("drop_clr2", {15'd0, drop}, 16'd0);

    // Load one cycle after dv (with a simultaneous dv) discards the sample.
    d = 16'd500; dv = 1'b1;
    step();
    load = 1'b1; load_val = -16'sd50;
    step();
    load = 1'b0; dv = 1'b0;
    chk_out("load_abort", -16'sd50, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("load_noqv", -16'sd50, 1'b0, 1'b0, 1'b0);
    step();
    chk("load_noqv2", {15'd0, qv}, 16'd0);

    // Full-scale swing without wrap.
    clamp = 16'hFFFF; rate = 16'hFFFF;
    load = 1'b1; load_val = 16'd32767;
    step();
    load = 1'b0;
    chk_out("load_max", 16'h7FFF, 1'b1, 1'b0, 1'b0);
    d = 16'h8000; dv = 1'b1;
    step();
    dv = 1'b0;
    step();
    chk_out("fullswing", 16'h8001, 1'b1, 1'b0, 1'b0);

    // rate=0 freezes q but still strobes qv.
    rate = 16'd0; d = 16'd0; dv = 1'b1;
    step();
    dv = 1'b0;
    step();
    chk_out("rate0", 16'h8001, 1'b1, 1'b1, 1'b0);

    // Lowered clamp does not snap q; it slews toward the new limit.
    clamp = 16'd100; rate = 16'd1000; d = 16'd0; dv = 1'b1;
    step();
    dv = 1'b0;
    step();
    chk_out("clamp_low", -16'sd31767, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
